plab2_proc_pipelined_bypass_dpath: RTL

PLAB2_PROC_PIPELINED_BYPASS_DPATH -- requirements
Module: plab2_proc_pipelined_bypass_dpath

---
 rtl/plab2_proc_dpath_pkg.sv | 34 +++
 rtl/plab2_proc_regfile_param.sv | 38 +++
 rtl/plab2_proc_pipelined_bypass_dpath.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/plab2_proc_dpath_pkg.sv
// Shared encodings for the pipelined bypass datapath: ALU functions,
// bypass sources, next-PC sources and op1 sources.
package plab2_proc_dpath_pkg;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_NOR  = 4'd5;
  localparam logic [3:0] ALU_SLT  = 4'd6;
  localparam logic [3:0] ALU_SLTU = 4'd7;
  localparam logic [3:0] ALU_SLL  = 4'd8;
  localparam logic [3:0] ALU_SRL  = 4'd9;
  localparam logic [3:0] ALU_SRA  = 4'd10;
  localparam logic [3:0] ALU_PASS = 4'd11;
  localparam logic [3:0] ALU_LUI  = 4'd12;

  localparam logic [1:0] BYP_RF = 2'd0;
  localparam logic [1:0] BYP_X  = 2'd1;
  localparam logic [1:0] BYP_M  = 2'd2;
  localparam logic [1:0] BYP_W  = 2'd3;

  localparam logic [1:0] PC_PLUS4 = 2'd0;
  localparam logic [1:0] PC_BR    = 2'd1;
  localparam logic [1:0] PC_J     = 2'd2;
  localparam logic [1:0] PC_JR    = 2'd3;

  localparam logic [1:0] OP1_RT   = 2'd0;
  localparam logic [1:0] OP1_SEXT = 2'd1;
  localparam logic [1:0] OP1_ZEXT = 2'd2;
  localparam logic [1:0] OP1_MNGR = 2'd3;

endpackage

// File: rtl/plab2_proc_regfile_param.sv
// Two-read, one-write register file; register 0 is hardwired to zero and
// a read of the address being written returns the incoming write data.
module plab2_proc_regfile_param
  import plab2_proc_dpath_pkg::*;
#(
  parameter int p_nbits    = 32,
  parameter int p_num_regs = 32,
  localparam int A = $clog2(p_num_regs)
) (
  input  logic               clk,
  input  logic [A-1:0]       raddr0,
  input  logic [A-1:0]       raddr1,
  input  logic               wen,
  input  logic [A-1:0]       waddr,
  input  logic [p_nbits-1:0] wdata,
  output logic [p_nbits-1:0] rdata0,
  output logic [p_nbits-1:0] rdata1
);

  logic [p_nbits-1:0] regs [p_num_regs];

  always_ff @(posedge clk) begin
    if (wen && (waddr != '0)) regs[waddr] <= wdata;
  end

  always_comb begin
    rdata0 = regs[raddr0];
    if (wen && (waddr == raddr0)) rdata0 = wdata;
    if (raddr0 == '0) rdata0 = '0;
  end

  always_comb begin
    rdata1 = regs[raddr1];
    if (wen && (waddr == raddr1)) rdata1 = wdata;
    if (raddr1 == '0) rdata1 = '0;
  end

endmodule

// File: rtl/plab2_proc_pipelined_bypass_dpath.sv
// Five-stage (F/D/X/M/W) processor datapath with full operand bypassing;
// all steering comes from an external control unit.
module plab2_proc_pipelined_bypass_dpath
  import plab2_proc_dpath_pkg::*;
#(
  parameter int                 p_nbits        = 32,
  parameter logic [p_nbits-1:0] p_reset_vector = p_nbits'(32'h1000),
  parameter int                 p_num_regs     = 32,
  localparam int A = $clog2(p_num_regs)
) (
  input  logic               clk,
  input  logic               reset,
  output logic [p_nbits-1:0] imemreq_msg_addr,
  input  logic [31:0]        imemresp_msg_data,
  output logic [p_nbits-1:0] dmemreq_msg_addr,
  output logic [p_nbits-1:0] dmemreq_msg_data,
  input  logic [p_nbits-1:0] dmemresp_msg_data,
  input  logic [p_nbits-1:0] from_mngr_data,
  output logic [p_nbits-1:0] to_mngr_data,
  input  logic [1:0]         pc_sel_F,
  input  logic               reg_en_F,
  input  logic               reg_en_D,
  input  logic               reg_en_X,
  input  logic               reg_en_M,
  input  logic               reg_en_W,
  input  logic               squash_D,
  input  logic [1:0]         op0_byp_sel_D,
  input  logic [1:0]         op1_byp_sel_D,
  input  logic [1:0]         op1_sel_D,
  input  logic [3:0]         alu_fn_X,
  input  logic               ex_result_sel_X,
  input  logic               wb_result_sel_M,
  input  logic [A-1:0]       rf_waddr_W,
  input  logic               rf_wen_W,
  output logic [31:0]        inst_D,
  output logic               br_cond_eq_X
);

  localparam int SW = $clog2(p_nbits);
  localparam logic [p_nbits-1:0] JMASK = p_nbits'(64'hFFFF_FFFF_F000_0000);

  logic [p_nbits-1:0] pc_plus4_F, pc_next_F, pc_plus4_D;
  logic [p_nbits-1:0] br_target_D, j_target_D, imm_sext_D, imm_zext_D;
  logic [p_nbits-1:0] rf_rdata0_D, rf_rdata1_D, op0_D, rt_byp_D, op1_D;
  logic [p_nbits-1:0] op0_X, op1_X, st_data_X, br_target_X, pc_plus4_X;
  logic [p_nbits-1:0] alu_out_X, ex_result_X, ex_result_M, wb_result_M, wb_result_W;
  logic [SW-1:0]      shamt_X;

  always_comb begin
    case (pc_sel_F)
      PC_PLUS4: pc_next_F = pc_plus4_F;
      PC_BR:    pc_next_F = br_target_X;
      PC_J:     pc_next_F = j_target_D;
      default:  pc_next_F = op0_D;
    endcase
  end
  assign imemreq_msg_addr = pc_next_F;

  assign imm_sext_D  = p_nbits'($signed(inst_D[15:0]));
  assign imm_zext_D  = p_nbits'(inst_D[15:0]);
  assign br_target_D = pc_plus4_D + (imm_sext_D << 2);
  // Upper PC bits above bit 27 survive; narrower datapaths simply drop them.
  assign j_target_D  = (pc_plus4_D & JMASK) | p_nbits'({inst_D[25:0], 2'b00});

  plab2_proc_regfile_param #(.p_nbits(p_nbits), .p_num_regs(p_num_regs)) u_rf (
    .clk    (clk),
    .raddr0 (inst_D[21 +: A]),
    .raddr1 (inst_D[16 +: A]),
    .wen    (rf_wen_W),
    .waddr  (rf_waddr_W),
    .wdata  (wb_result_W),
    .rdata0 (rf_rdata0_D),
    .rdata1 (rf_rdata1_D)
  );

  always_comb begin
    case (op0_byp_sel_D)
      BYP_RF:  op0_D = rf_rdata0_D;
      BYP_X:   op0_D = ex_result_X;
      BYP_M:   op0_D = wb_result_M;
      default: op0_D = wb_result_W;
    endcase
  end

  always_comb begin
    case (op1_byp_sel_D)
      BYP_RF:  rt_byp_D = rf_rdata1_D;
      BYP_X:   rt_byp_D = ex_result_X;
      BYP_M:   rt_byp_D = wb_result_M;
      default: rt_byp_D = wb_result_W;
    endcase
  end

  always_comb begin
    case (op1_sel_D)
      OP1_RT:   op1_D = rt_byp_D;
      OP1_SEXT: op1_D = imm_sext_D;
      OP1_ZEXT: op1_D = imm_zext_D;
      default:  op1_D = from_mngr_data;
    endcase
  end

  assign shamt_X = op1_X[SW-1:0];

  always_comb begin
    case (alu_fn_X)
      ALU_ADD:  alu_out_X = op0_X + op1_X;
      ALU_SUB:  alu_out_X = op0_X - op1_X;
      ALU_AND:  alu_out_X = op0_X & op1_X;
      ALU_OR:   alu_out_X = op0_X | op1_X;
      ALU_XOR:  alu_out_X = op0_X ^ op1_X;
      ALU_NOR:  alu_out_X = ~(op0_X | op1_X);
      ALU_SLT:  alu_out_X = p_nbits'($signed(op0_X) < $signed(op1_X));
      ALU_SLTU: alu_out_X = p_nbits'(op0_X < op1_X);
      ALU_SLL:  alu_out_X = op0_X << shamt_X;
      ALU_SRL:  alu_out_X = op0_X >> shamt_X;
      ALU_SRA:  alu_out_X = $unsigned($signed(op0_X) >>> shamt_X);
      ALU_PASS: alu_out_X = op1_X;
      ALU_LUI:  alu_out_X = op1_X << 16;
      default:  alu_out_X = '0;
    endcase
  end

  assign ex_result_X      = ex_result_sel_X ? pc_plus4_X : alu_out_X;
  assign br_cond_eq_X     = (op0_X == op1_X);
  assign dmemreq_msg_addr = alu_out_X;
  assign dmemreq_msg_data = st_data_X;
  assign wb_result_M      = wb_result_sel_M ? dmemresp_msg_data : ex_result_M;
  assign to_mngr_data     = wb_result_W;

  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_plus4_F  <= p_reset_vector;
      pc_plus4_D  <= '0;
      inst_D      <= '0;
      op0_X       <= '0;
      op1_X       <= '0;
      st_data_X   <= '0;
      br_target_X <= '0;
      pc_plus4_X  <= '0;
      ex_result_M <= '0;
      wb_result_W <= '0;
    end else begin
      if (reg_en_F) pc_plus4_F <= pc_next_F + p_nbits'(4);
      if (reg_en_D) begin
        pc_plus4_D <= pc_plus4_F;
        inst_D     <= squash_D ? 32'h0 : imemresp_msg_data;
      end
      if (reg_en_X) begin
        op0_X       <= op0_D;
        op1_X       <= op1_D;
        st_data_X   <= rt_byp_D;
        br_target_X <= br_target_D;
        pc_plus4_X  <= pc_plus4_D;
      end
      if (reg_en_M) ex_result_M <= ex_result_X;
      if (reg_en_W) wb_result_W <= wb_result_M;
    end
  end

endmodule
